// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron : clocked leaky integrate-and-fire neuron.
//
// Each accepted step sums the weights of the active synaptic inputs into the
// membrane potential, fires a registered spike when the potential reaches the
// threshold, and otherwise leaks the potential toward the rest value. After a
// spike the neuron ignores REFRAC_STEPS accepted steps.
//
// Ports:
//   mem_clk       single clock for all logic
//   rst           synchronous, active-low reset
//   step_valid    one accepted timestep per high cycle
//   spike_in      input spikes, sampled only on accepted steps
//   spike_out     registered one-cycle spike pulse
//   refractory    high while the refractory counter is nonzero
//   potential_out membrane potential register (signed)
//   mem_addr      0..NUM_INPUTS-1 weights, NUM_INPUTS threshold, +1 leak
//   mem_din       write data (sign-extended for threshold, zero for leak)
//   mem_wen       write enable
//   mem_dout      registered read data
// -----------------------------------------------------------------------------
module lif_neuron #(
  parameter int NUM_INPUTS        = 4,
  parameter int WEIGHT_SIZE       = 32,
  parameter int POT_WIDTH         = 2*WEIGHT_SIZE,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter logic signed [POT_WIDTH-1:0] THRESH = POT_WIDTH'(10),
  parameter logic signed [POT_WIDTH-1:0] RESET  = POT_WIDTH'(0),
  parameter logic        [POT_WIDTH-1:0] LEAK   = POT_WIDTH'(1),
  parameter int REFRAC_STEPS      = 2,
  parameter int RESET_MODE        = 0
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  input  logic                          step_valid,
  input  logic [NUM_INPUTS-1:0]         spike_in,
  output logic                          spike_out,
  output logic                          refractory,
  output logic signed [POT_WIDTH-1:0]   potential_out,
  input  logic [WEIGHT_ADDR_WIDTH-1:0]  mem_addr,
  input  logic [WEIGHT_SIZE-1:0]        mem_din,
  input  logic                          mem_wen,
  output logic [WEIGHT_SIZE-1:0]        mem_dout
);

  // Wide enough that potential plus every weight can never overflow.
  localparam int SW = POT_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int CW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] ADDR_THR  = WEIGHT_ADDR_WIDTH'(NUM_INPUTS);
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] ADDR_LEAK = WEIGHT_ADDR_WIDTH'(NUM_INPUTS + 1);
  localparam logic signed [SW-1:0] P_MAX_X = {{(SW-POT_WIDTH+1){1'b0}}, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] P_MIN_X = {{(SW-POT_WIDTH+1){1'b1}}, {(POT_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] REST_X  = {{(SW-POT_WIDTH){RESET[POT_WIDTH-1]}}, RESET};

  function automatic logic signed [SW-1:0] sext_pot(input logic signed [POT_WIDTH-1:0] v);
    sext_pot = {{(SW-POT_WIDTH){v[POT_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] sext_w(input logic signed [WEIGHT_SIZE-1:0] v);
    sext_w = {{(SW-WEIGHT_SIZE){v[WEIGHT_SIZE-1]}}, v};
  endfunction

  // Clamp a wide intermediate into the signed potential range.
  function automatic logic signed [POT_WIDTH-1:0] sat_pot(input logic signed [SW-1:0] v);
    if (v > P_MAX_X) begin
      sat_pot = {1'b0, {(POT_WIDTH-1){1'b1}}};
    end else if (v < P_MIN_X) begin
      sat_pot = {1'b1, {(POT_WIDTH-1){1'b0}}};
    end else begin
      sat_pot = v[POT_WIDTH-1:0];
    end
  endfunction

  logic signed [WEIGHT_SIZE-1:0] r_weight [NUM_INPUTS];
  logic signed [POT_WIDTH-1:0]   r_thresh;
  logic        [POT_WIDTH-1:0]   r_leak;
  logic signed [POT_WIDTH-1:0]   r_pot;
  logic        [CW-1:0]          r_cnt;
  logic                          r_spike;
  logic        [WEIGHT_SIZE-1:0] r_dout;

  logic signed [SW-1:0]          w_sum;
  logic signed [POT_WIDTH-1:0]   w_p1;
  logic signed [SW-1:0]          w_p1_x;
  logic signed [SW-1:0]          w_leak_x;
  logic signed [SW-1:0]          w_dist;
  logic signed [SW-1:0]          w_step;
  logic signed [POT_WIDTH-1:0]   w_pot_nxt;
  logic        [CW-1:0]          w_cnt_nxt;
  logic                          w_spike_nxt;
  logic        [WEIGHT_SIZE-1:0] w_rd;
  logic        [IW-1:0]          w_widx;
  logic                          w_wr_weight;

  assign w_widx      = mem_addr[IW-1:0];
  assign w_wr_weight = mem_wen && (mem_addr < ADDR_THR);

  // Synaptic sum and saturated integrated potential.
  always_comb begin
    w_sum = {SW{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_sum = w_sum + (spike_in[i] ? sext_w(r_weight[i]) : {SW{1'b0}});
    end
    w_p1     = sat_pot(sext_pot(r_pot) + w_sum);
    w_p1_x   = sext_pot(w_p1);
    w_leak_x = {{(SW-POT_WIDTH){1'b0}}, r_leak};
  end

  // Next neuron state: refractory hold, fire, or leak toward rest.
  always_comb begin
    w_pot_nxt   = r_pot;
    w_cnt_nxt   = r_cnt;
    w_spike_nxt = 1'b0;
    w_dist      = {SW{1'b0}};
    w_step      = {SW{1'b0}};
    if (step_valid) begin
      if (r_cnt != {CW{1'b0}}) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end else if (w_p1 >= r_thresh) begin
        w_spike_nxt = 1'b1;
        w_cnt_nxt   = CW'(REFRAC_STEPS);
        if (RESET_MODE == 1) begin
          w_pot_nxt = sat_pot(w_p1_x - sext_pot(r_thresh));
        end else begin
          w_pot_nxt = RESET;
        end
      end else if (w_p1 > RESET) begin
        // Leak is capped at the distance to rest so it never overshoots.
        w_dist    = w_p1_x - REST_X;
        w_step    = (w_leak_x < w_dist) ? w_leak_x : w_dist;
        w_pot_nxt = sat_pot(w_p1_x - w_step);
      end else if (w_p1 < RESET) begin
        w_dist    = REST_X - w_p1_x;
        w_step    = (w_leak_x < w_dist) ? w_leak_x : w_dist;
        w_pot_nxt = sat_pot(w_p1_x + w_step);
      end else begin
        w_pot_nxt = w_p1;
      end
    end else begin
      w_pot_nxt = r_pot;
    end
  end

  // Read mux; registered below so a same-cycle write returns the old value.
  always_comb begin
    w_rd = {WEIGHT_SIZE{1'b0}};
    if (mem_addr < ADDR_THR) begin
      w_rd = r_weight[w_widx];
    end else if (mem_addr == ADDR_THR) begin
      w_rd = r_thresh[WEIGHT_SIZE-1:0];
    end else if (mem_addr == ADDR_LEAK) begin
      w_rd = r_leak[WEIGHT_SIZE-1:0];
    end else begin
      w_rd = {WEIGHT_SIZE{1'b0}};
    end
  end

  // Neuron state registers.
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      r_pot   <= RESET;
      r_cnt   <= {CW{1'b0}};
      r_spike <= 1'b0;
    end else begin
      r_pot   <= w_pot_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spike <= w_spike_nxt;
    end
  end

  // Weight/config storage and read data register.
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_weight[i] <= WEIGHT_SIZE'(1);
      end
      r_thresh <= THRESH;
      r_leak   <= LEAK;
      r_dout   <= {WEIGHT_SIZE{1'b0}};
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_wr_weight && (w_widx == IW'(i))) begin
          r_weight[i] <= mem_din;
        end
      end
      if (mem_wen && (mem_addr == ADDR_THR)) begin
        r_thresh <= POT_WIDTH'(signed'(mem_din));
      end
      if (mem_wen && (mem_addr == ADDR_LEAK)) begin
        r_leak <= POT_WIDTH'(mem_din);
      end
      r_dout <= w_rd;
    end
  end

  assign spike_out     = r_spike;
  assign refractory    = (r_cnt != {CW{1'b0}});
  assign potential_out = r_pot;
  assign mem_dout      = r_dout;

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sv0 = 1'b0, sv1 = 1'b0, sv2 = 1'b0;
  logic        wen0 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
  logic [3:0]  spk = 4'b0000;
  logic [7:0]  addr = 8'd0;
  logic [31:0] din = 32'd0;

  logic               so0, rf0, so1, rf1, so2, rf2;
  logic signed [63:0] pot0, pot1;
  logic signed [7:0]  pot2;
  logic [31:0]        dout0, dout1;
  logic [7:0]         dout2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_neuron dut (
    .mem_clk(clk), .rst(rst), .step_valid(sv0), .spike_in(spk),
    .spike_out(so0), .refractory(rf0), .potential_out(pot0),
    .mem_addr(addr), .mem_din(din), .mem_wen(wen0), .mem_dout(dout0));

  lif_neuron #(.RESET_MODE(1)) dut_m1 (
    .mem_clk(clk), .rst(rst), .step_valid(sv1), .spike_in(spk),
    .spike_out(so1), .refractory(rf1), .potential_out(pot1),
    .mem_addr(addr), .mem_din(din), .mem_wen(wen1), .mem_dout(dout1));

  lif_neuron #(.WEIGHT_SIZE(8), .POT_WIDTH(8), .LEAK(8'd0), .THRESH(8'sd127)) dut_s (
    .mem_clk(clk), .rst(rst), .step_valid(sv2), .spike_in(spk),
    .spike_out(so2), .refractory(rf2), .potential_out(pot2),
    .mem_addr(addr), .mem_din(din[7:0]), .mem_wen(wen2), .mem_dout(dout2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; sv0 = 1'b1; wen0 = 1'b1; addr = 8'd0; din = 32'd9; spk = 4'b1111;
    tick();
    rst = 1'b1; sv0 = 1'b0; wen0 = 1'b0;
    total++; if (pot0 !== 64'sd0) begin bad++; $display("FAIL rst_pot got=%0d want=0", pot0); end
    total++; if (so0 !== 1'b0) begin bad++; $display("FAIL rst_spike got=%0b want=0", so0); end
    total++; if (rf0 !== 1'b0) begin bad++; $display("FAIL rst_refr got=%0b want=0", rf0); end
    total++; if (dout0 !== 32'd0) begin bad++; $display("FAIL rst_dout got=%0h want=0", dout0); end
    tick();
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL rst_w0 got=%0h want=1", dout0); end
    addr = 8'd3; tick();
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL rst_w3 got=%0h want=1", dout0); end
    addr = 8'd4; tick();
    total++; if (dout0 !== 32'd10) begin bad++; $display("FAIL rst_thr got=%0h want=a", dout0); end
    addr = 8'd5; tick();
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL rst_leak got=%0h want=1", dout0); end
  endtask

  task automatic test_integrate();
    sv0 = 1'b1; spk = 4'b1111;
    tick();
    total++; if (pot0 !== 64'sd3 || so0 !== 1'b0) begin bad++; $display("FAIL int_step1 pot=%0d spk=%0b want 3/0", pot0, so0); end
    tick();
    total++; if (pot0 !== 64'sd6 || so0 !== 1'b0) begin bad++; $display("FAIL int_step2 pot=%0d spk=%0b want 6/0", pot0, so0); end
    tick();
    total++; if (so0 !== 1'b1) begin bad++; $display("FAIL int_fire got=%0b want=1", so0); end
    total++; if (pot0 !== 64'sd0) begin bad++; $display("FAIL int_fire_pot got=%0d want=0", pot0); end
    total++; if (rf0 !== 1'b1) begin bad++; $display("FAIL int_fire_refr got=%0b want=1", rf0); end
    sv0 = 1'b0;
    tick();
    total++; if (so0 !== 1'b0 || rf0 !== 1'b1) begin bad++; $display("FAIL int_pulse spk=%0b refr=%0b want 0/1", so0, rf0); end
  endtask

  task automatic test_refractory();
    sv0 = 1'b1; spk = 4'b1111;
    tick();
    total++; if (pot0 !== 64'sd0 || rf0 !== 1'b1 || so0 !== 1'b0) begin bad++; $display("FAIL ref_s1 pot=%0d refr=%0b spk=%0b want 0/1/0", pot0, rf0, so0); end
    tick();
    total++; if (pot0 !== 64'sd0 || rf0 !== 1'b0) begin bad++; $display("FAIL ref_s2 pot=%0d refr=%0b want 0/0", pot0, rf0); end
    tick();
    total++; if (pot0 !== 64'sd3) begin bad++; $display("FAIL ref_s3 got=%0d want=3", pot0); end
    sv0 = 1'b0;
    tick(); tick();
    total++; if (pot0 !== 64'sd3) begin bad++; $display("FAIL ref_idle_hold got=%0d want=3", pot0); end
  endtask

  task automatic test_write_read();
    addr = 8'd0; din = 32'hFFFF_FFFB; wen0 = 1'b1;
    tick();
    wen0 = 1'b0;
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL wr_old got=%0h want=1", dout0); end
    tick();
    total++; if (dout0 !== 32'hFFFF_FFFB) begin bad++; $display("FAIL wr_new got=%0h want=fffffffb", dout0); end
    sv0 = 1'b1; spk = 4'b0001;
    tick();
    sv0 = 1'b0;
    total++; if (pot0 !== -64'sd1 || so0 !== 1'b0) begin bad++; $display("FAIL wr_neg_leak pot=%0d spk=%0b want -1/0", pot0, so0); end
  endtask

  task automatic test_reset_mode1();
    sv1 = 1'b1; spk = 4'b1111;
    tick(); tick();
    sv1 = 1'b0;
    total++; if (pot1 !== 64'sd6) begin bad++; $display("FAIL m1_pre got=%0d want=6", pot1); end
    wen1 = 1'b1; din = 32'd3;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i); tick();
    end
    wen1 = 1'b0;
    sv1 = 1'b1;
    tick();
    total++; if (so1 !== 1'b1 || pot1 !== 64'sd8) begin bad++; $display("FAIL m1_sub spk=%0b pot=%0d want 1/8", so1, pot1); end
    tick();
    sv1 = 1'b0;
    total++; if (so1 !== 1'b0 || pot1 !== 64'sd8 || rf1 !== 1'b1) begin bad++; $display("FAIL m1_refr spk=%0b pot=%0d refr=%0b want 0/8/1", so1, pot1, rf1); end
  endtask

  task automatic test_saturation();
    wen2 = 1'b1; din = 32'd100;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i); tick();
    end
    wen2 = 1'b0;
    sv2 = 1'b1; spk = 4'b1111;
    tick();
    total++; if (so2 !== 1'b1 || pot2 !== 8'sd0) begin bad++; $display("FAIL sat_hi spk=%0b pot=%0d want 1/0", so2, pot2); end
    spk = 4'b0000;
    tick(); tick();
    sv2 = 1'b0;
    total++; if (rf2 !== 1'b0 || pot2 !== 8'sd0) begin bad++; $display("FAIL sat_refr refr=%0b pot=%0d want 0/0", rf2, pot2); end
    wen2 = 1'b1; din = 32'h9C;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i); tick();
    end
    wen2 = 1'b0;
    sv2 = 1'b1; spk = 4'b1111;
    tick();
    total++; if (pot2 !== 8'h80 || so2 !== 1'b0) begin bad++; $display("FAIL sat_lo pot=%0d spk=%0b want -128/0", pot2, so2); end
    tick();
    sv2 = 1'b0;
    total++; if (pot2 !== 8'h80) begin bad++; $display("FAIL sat_lo_hold got=%0d want=-128", pot2); end
  endtask

  task automatic test_back_to_back_cfg();
    rst = 1'b0; tick(); rst = 1'b1;
    sv0 = 1'b1; spk = 4'b1111; wen0 = 1'b1; addr = 8'd4; din = 32'd3;
    tick();
    wen0 = 1'b0;
    total++; if (pot0 !== 64'sd3 || so0 !== 1'b0) begin bad++; $display("FAIL cfg_old_thr pot=%0d spk=%0b want 3/0", pot0, so0); end
    spk = 4'b0000;
    tick();
    sv0 = 1'b0;
    total++; if (so0 !== 1'b1 || pot0 !== 64'sd0 || rf0 !== 1'b1) begin bad++; $display("FAIL cfg_new_thr spk=%0b pot=%0d refr=%0b want 1/0/1", so0, pot0, rf0); end
    total++; if (dout0 !== 32'd3) begin bad++; $display("FAIL cfg_thr_rd got=%0h want=3", dout0); end
    addr = 8'd200; din = 32'h55; wen0 = 1'b1;
    tick();
    wen0 = 1'b0;
    total++; if (dout0 !== 32'd0) begin bad++; $display("FAIL oob_rd got=%0h want=0", dout0); end
    addr = 8'd0;
    tick();
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL oob_alias got=%0h want=1", dout0); end
    total++; if (rf0 !== 1'b1) begin bad++; $display("FAIL pre_rst_refr got=%0b want=1", rf0); end
    rst = 1'b0; sv0 = 1'b1; spk = 4'b1111; wen0 = 1'b1; addr = 8'd0; din = 32'd7;
    tick();
    total++; if (pot0 !== 64'sd0 || so0 !== 1'b0 || rf0 !== 1'b0 || dout0 !== 32'd0) begin
      bad++; $display("FAIL mid_rst pot=%0d spk=%0b refr=%0b dout=%0h want 0/0/0/0", pot0, so0, rf0, dout0);
    end
    rst = 1'b1; sv0 = 1'b0; wen0 = 1'b0;
    tick();
    total++; if (dout0 !== 32'd1) begin bad++; $display("FAIL mid_rst_w0 got=%0h want=1", dout0); end
    addr = 8'd4;
    tick();
    total++; if (dout0 !== 32'd10) begin bad++; $display("FAIL mid_rst_thr got=%0h want=a", dout0); end
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_refractory();
    test_write_read();
    test_reset_mode1();
    test_saturation();
    test_back_to_back_cfg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
